// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and counter sizing for the memory arbiter
package mem_arb_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {IDLE, ISS_IF, ISS_DM, BSY_IF, BSY_DM} state_e;
  function automatic int starve_w(input int limit);
    return $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: data-first winner select with a forced fetch win once fetch is starved
module arb_pick (
  input  logic if_req,
  input  logic dm_req,
  input  logic if_elig,
  input  logic dm_elig,
  input  logic starve,
  output logic grant_if,
  output logic grant_dm
);
  logic if_ok, dm_ok;
  always_comb begin
    if_ok = if_req & if_elig;
    dm_ok = dm_req & dm_elig;
    grant_dm = dm_ok & ~(starve & if_ok);
    grant_if = if_ok & ~grant_dm;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory between fetch and data ports, one access in flight
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_stall,
  input  logic        mem_done
);
  localparam int STARVE_W = starve_w(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
  state_e state_q;
  logic [STARVE_W-1:0] starve_q;
  logic [15:0] if_rdata_q, dm_rdata_q;
  logic if_done_q, dm_done_q;
  logic grant_if, grant_dm, issue_if, issue_dm, accept;
  arb_pick u_pick (
    .if_req  (if_req),
    .dm_req  (dm_req),
    .if_elig (~if_done_q),
    .dm_elig (~dm_done_q),
    .starve  (starve_q == LIMIT),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );
  // issue is gated by reset so the memory sees nothing while rst is held low
  always_comb begin
    issue_if = rst & (((state_q == IDLE) & grant_if) | (state_q == ISS_IF));
    issue_dm = rst & (((state_q == IDLE) & grant_dm) | (state_q == ISS_DM));
    mem_en = issue_if | issue_dm;
    mem_wr = issue_dm & dm_wr;
    mem_addr = issue_dm ? dm_addr : issue_if ? if_addr : '0;
    mem_wdata = issue_dm ? dm_wdata : '0;
    accept = mem_en & ~mem_stall;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      starve_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      case (state_q)
        IDLE, ISS_IF, ISS_DM:
          if (mem_en) state_q <= accept ? (issue_dm ? BSY_DM : BSY_IF) : (issue_dm ? ISS_DM : ISS_IF);
        BSY_IF:
          if (mem_done) begin
            state_q <= IDLE;
            if_done_q <= 1'b1;
            if_rdata_q <= mem_rdata;
          end
        BSY_DM:
          if (mem_done) begin
            state_q <= IDLE;
            dm_done_q <= 1'b1;
            if (!dm_wr) dm_rdata_q <= mem_rdata;
          end
        default: state_q <= IDLE;
      endcase
      if (accept & issue_if) starve_q <= '0;
      else if (accept & issue_dm) starve_q <= !if_req ? '0 : (starve_q == LIMIT) ? starve_q : starve_q + STARVE_W'(1);
    end
  end
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign if_done = if_done_q;
  assign dm_done = dm_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios, then random traffic checked against a transaction-level model
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  logic clk = 0, rst = 0;
  logic if_req = 0, dm_req = 0, dm_wr = 0, mem_stall = 0, mem_done = 0;
  logic [15:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_done, dm_done, mem_en, mem_wr;
  int checks = 0, errors = 0;
  logic [15:0] memarr [65536];
  bit busy, busy_end, locked, lk_dm, bsy_dm, bsy_wr, exp_if_done, exp_dm_done, cif, cdm, eif, edm, wdm, go;
  int lat, cnt;
  logic [15:0] bsy_addr, bsy_wdata, exp_if_rdata, exp_dm_rdata;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic busy_done(input logic [15:0] rd);
    mem_done = 1;
    mem_rdata = rd;
    #1;
    chk("bsy_en", mem_en, 0);
    chk("bsy_nodone", {if_done, dm_done}, 0);
    tick;
    mem_done = 0;
    mem_rdata = 0;
  endtask

  task automatic starve_round(input string tag);
    dm_req = 1; dm_wr = 0; dm_addr = 16'h0400;
    for (int i = 0; i < LIMIT; i++) begin
      if_req = 1; if_addr = 16'h0060;
      #1;
      chk({tag, "_dm_win"}, mem_addr, 16'h0400);
      tick;
      if_req = 0;
      busy_done(16'(16'h4000 + i));
      #1;
      chk({tag, "_dm_data"}, dm_rdata, 16'(16'h4000 + i));
      chk({tag, "_gap"}, mem_en, 0);
      tick;
    end
    if_req = 1;
    #1;
    chk({tag, "_if_win"}, mem_addr, 16'h0060);
    dm_req = 0;
    tick;
    busy_done(16'h6666);
    #1;
    chk({tag, "_if_done"}, if_done, 1);
    chk({tag, "_if_data"}, if_rdata, 16'h6666);
    if_req = 0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) memarr[a] = 16'(a) ^ 16'h5A3C;
    #12;
    chk("rst_en", mem_en, 0);
    chk("rst_dones", {if_done, dm_done}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst = 1;
    tick;
    // single fetch
    if_req = 1; if_addr = 16'h0010;
    #1;
    chk("f1_en", mem_en, 1);
    chk("f1_addr", mem_addr, 16'h0010);
    chk("f1_wr", mem_wr, 0);
    tick;
    busy_done(16'hA5A5);
    #1;
    chk("f1_done", if_done, 1);
    chk("f1_data", if_rdata, 16'hA5A5);
    chk("f1_dm_done", dm_done, 0);
    chk("f1_dm_data", dm_rdata, 0);
    chk("f1_inelig", mem_en, 0);
    if_req = 0;
    tick;
    #1;
    chk("f1_pulse", if_done, 0);
    // simultaneous requests
    if_req = 1; if_addr = 16'h0020; dm_req = 1; dm_wr = 0; dm_addr = 16'h0100;
    #1;
    chk("s2_first", mem_addr, 16'h0100);
    tick;
    busy_done(16'h1111);
    #1;
    chk("s2_dm_done", dm_done, 1);
    chk("s2_dm_data", dm_rdata, 16'h1111);
    chk("s2_if_en", mem_en, 1);
    chk("s2_if_addr", mem_addr, 16'h0020);
    dm_req = 0;
    tick;
    busy_done(16'h2222);
    #1;
    chk("s2_if_done", if_done, 1);
    chk("s2_if_data", if_rdata, 16'h2222);
    chk("s2_dm_quiet", dm_done, 0);
    if_req = 0;
    tick;
    // stalled write, fetch arrives meanwhile
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0200; dm_wdata = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      mem_stall = (i < 3);
      if (i == 1) begin if_req = 1; if_addr = 16'h0030; end
      #1;
      chk("st_en", mem_en, 1);
      chk("st_addr", mem_addr, 16'h0200);
      chk("st_wr", mem_wr, 1);
      chk("st_wdata", mem_wdata, 16'hBEEF);
      tick;
    end
    mem_stall = 0;
    busy_done(16'hDEAD);
    #1;
    chk("st_done", dm_done, 1);
    chk("st_rdata_kept", dm_rdata, 16'h1111);
    chk("st_if_addr", mem_addr, 16'h0030);
    chk("st_if_wr", mem_wr, 0);
    dm_req = 0; dm_wr = 0;
    tick;
    busy_done(16'h3333);
    #1;
    chk("st_if_done", if_done, 1);
    chk("st_if_data", if_rdata, 16'h3333);
    if_req = 0;
    tick;
    // starvation guard, twice to show the count restarts
    starve_round("sv1");
    starve_round("sv2");
    // reset during a fetch access
    if_req = 1; if_addr = 16'h0040;
    #1;
    chk("r_en", mem_en, 1);
    tick;
    #1;
    chk("r_bsy", mem_en, 0);
    rst = 0;
    #1;
    chk("r_en0", mem_en, 0);
    chk("r_if_rdata", if_rdata, 0);
    chk("r_dm_rdata", dm_rdata, 0);
    chk("r_dones", {if_done, dm_done}, 0);
    if_req = 0;
    tick;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("r_no_done", if_done, 0);
      tick;
    end
    if_req = 1; if_addr = 16'h0050;
    #1;
    chk("r_new_addr", mem_addr, 16'h0050);
    tick;
    busy_done(16'h5555);
    #1;
    chk("r_new_done", if_done, 1);
    chk("r_new_data", if_rdata, 16'h5555);
    if_req = 0;
    tick;
    // variable latency with fetch waiting through the busy window
    dm_req = 1; dm_wr = 0; dm_addr = 16'h0300;
    #1;
    chk("v_addr", mem_addr, 16'h0300);
    tick;
    if_req = 1; if_addr = 16'h0070;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("v_bsy_en", mem_en, 0);
      chk("v_no_done", dm_done, 0);
      tick;
    end
    busy_done(16'h7777);
    #1;
    chk("v_done", dm_done, 1);
    chk("v_data", dm_rdata, 16'h7777);
    chk("v_if_addr", mem_addr, 16'h0070);
    dm_req = 0;
    tick;
    busy_done(16'h8888);
    #1;
    chk("v_if_done", if_done, 1);
    if_req = 0;
    tick;
    // randomized traffic
    rst = 0;
    #1;
    rst = 1;
    tick;
    busy = 0; locked = 0; cnt = 0; exp_if_done = 0; exp_dm_done = 0;
    exp_if_rdata = 0; exp_dm_rdata = 0;
    for (int c = 0; c < 3000; c++) begin
      cif = exp_if_done; cdm = exp_dm_done;
      exp_if_done = 0; exp_dm_done = 0;
      chk("rnd_if_done", if_done, cif);
      chk("rnd_dm_done", dm_done, cdm);
      chk("rnd_if_rdata", if_rdata, exp_if_rdata);
      chk("rnd_dm_rdata", dm_rdata, exp_dm_rdata);
      if (cif) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = {1'b0, 15'($urandom_range(0, 63))};
      end
      if (cdm) dm_req = 0;
      else if (!dm_req && $urandom_range(0, 1) == 0) begin
        dm_req = 1; dm_wr = 1'($urandom_range(0, 1));
        dm_addr = {1'b1, 15'($urandom_range(0, 63))}; dm_wdata = 16'($urandom);
      end
      mem_done = 0; mem_rdata = 16'($urandom); busy_end = 0;
      if (busy) begin
        if (lat == 0) begin
          mem_done = 1; busy_end = 1;
          if (bsy_wr) memarr[bsy_addr] = bsy_wdata;
          else mem_rdata = memarr[bsy_addr];
          if (bsy_dm) begin
            exp_dm_done = 1;
            if (!bsy_wr) exp_dm_rdata = mem_rdata;
          end else begin
            exp_if_done = 1; exp_if_rdata = mem_rdata;
          end
        end else lat--;
      end else if ($urandom_range(0, 15) == 0) mem_done = 1;
      mem_stall = ($urandom_range(0, 3) == 0);
      #1;
      if (busy) begin
        chk("rnd_bsy_en", mem_en, 0);
        if (busy_end) busy = 0;
      end else begin
        go = locked;
        if (locked) wdm = lk_dm;
        else begin
          eif = if_req && !cif; edm = dm_req && !cdm;
          wdm = edm && !(cnt == LIMIT && eif);
          go = eif || edm;
        end
        chk("rnd_en", mem_en, go);
        if (go) begin
          chk("rnd_addr", mem_addr, wdm ? dm_addr : if_addr);
          chk("rnd_wr", mem_wr, wdm & dm_wr);
          chk("rnd_wdata", mem_wdata, wdm ? dm_wdata : 16'h0);
          if (!mem_stall) begin
            busy = 1; locked = 0; lat = $urandom_range(0, 4);
            bsy_dm = wdm; bsy_wr = wdm & dm_wr;
            bsy_addr = wdm ? dm_addr : if_addr; bsy_wdata = dm_wdata;
            cnt = !wdm ? 0 : !if_req ? 0 : (cnt < LIMIT ? cnt + 1 : cnt);
          end else begin
            locked = 1; lk_dm = wdm;
          end
        end else begin
          chk("rnd_idle_addr", mem_addr, 0);
          chk("rnd_idle_wdata", mem_wdata, 0);
          chk("rnd_idle_wr", mem_wr, 0);
        end
      end
      tick;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-ported, multi-cycle 16-bit unified memory between the fetch stage (instruction port) and the memory stage (data port). It sits between the two pipeline stages and the memory macro, accepts one outstanding request at a time, and handles the memory's stall/done handshake. It returns registered read data and a one-cycle done pulse to the granted requester. Data port has priority; a starvation counter guarantees fetch progress.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive data-port acceptances while fetch is waiting before fetch is forced to win (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  16  fetch address (PC), stable while if_req
- if_rdata  out  16  registered instruction word
- if_done  out  1  one-cycle pulse, if_rdata valid
- dm_req  in  1  data request, level, held until dm_done
- dm_wr  in  1  1 = write, 0 = read
- dm_addr  in  16  data address
- dm_wdata  in  16  write data
- dm_rdata  out  16  registered load data
- dm_done  out  1  one-cycle pulse, dm_rdata valid (reads) / write complete
- mem_en  out  1  issue strobe to memory
- mem_wr  out  1  write select to memory
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid with mem_done
- mem_stall  in  1  memory cannot accept this cycle
- mem_done  in  1  memory completes the accepted access (reads and writes)

## Operation
- States: IDLE, ISS_IF, ISS_DM, BSY_IF, BSY_DM.
- IDLE: choose winner among eligible requests; mem_en=1 with winner's fields the same cycle. If neither requests, mem_en=0.
- Winner rule: dm wins over if, except if starve_cnt == STARVE_LIMIT and both request, then if wins.
- Acceptance = mem_en & ~mem_stall. Accepted -> BSY_x. Stalled -> ISS_x (winner locked; re-issue same fields every cycle until accepted; no re-arbitration).
- BSY_x: mem_en=0; wait for mem_done. On mem_done: capture mem_rdata into x_rdata (reads only; dm write leaves dm_rdata unchanged), go IDLE, x_done=1 next cycle.
- A port whose done is high in the current cycle is ineligible that cycle (prevents re-issue of the completing request).
- starve_cnt: +1 (saturating at STARVE_LIMIT) on each dm acceptance while if_req=1; cleared on if acceptance or on a dm acceptance with if_req=0.
- mem_wr = dm_wr only when dm is issuing, else 0. mem_addr/mem_wdata = 0 when mem_en=0.
- mem_done in IDLE/ISS_x is ignored (protocol error, no state change).

## Timing
- Reset (rst low, async): state IDLE, if_done=dm_done=0, if_rdata=dm_rdata=0, starve_cnt=0, mem_en=0. In-flight access is abandoned; memory shares rst.
- Minimum latency: issue cycle N, mem_done N+1, x_done and x_rdata in N+2.
- Back-to-back: next issue is possible in cycle N+2 (done cycle), to the other port only, or to either port at N+3.
- Issue outputs (mem_en, mem_addr, mem_wr, mem_wdata) are combinational from state and requests; all requester-facing outputs are registered.
- Request dropped before done: undefined; requesters must hold req.

## Structure
- Package mem_arb_pkg: state enum, state width, STARVE_W = clog2(STARVE_LIMIT+1).
- One sub-module arb_pick: combinational winner select (inputs if_req, dm_req, eligibility masks, starve flag; output grant_if, grant_dm). FSM, counter and output registers stay in mem_arbiter.

## Test plan
- Single fetch: if_req=1, if_addr=0x0010, mem_done one cycle after issue with mem_rdata=0xA5A5 -> if_done pulse at N+2, if_rdata=0xA5A5, dm outputs unchanged.
- Simultaneous requests: if_addr=0x0020, dm read dm_addr=0x0100 -> dm issued first, then fetch issued in dm_done cycle; two done pulses, correct data to each.
- Stall on issue: mem_stall=1 for 3 cycles with dm write 0x0200/0xBEEF -> mem_en held 4 cycles, same fields; if_req arriving meanwhile does not preempt; dm_done after mem_done, dm_rdata unchanged.
- Starvation: dm_req continuously high, if_req high, STARVE_LIMIT=4 -> exactly 4 dm acceptances, then fetch accepted, starve_cnt returns to 0.
- Reset mid-access: rst low during BSY_IF -> all outputs 0 immediately, no if_done after release; new if_req after release completes normally.
- Variable latency: mem_done 5 cycles after acceptance -> x_done exactly one cycle after mem_done, mem_en low throughout BSY.
